// File: rtl/uart8_rx_tx.sv
// 8N1 UART: 16x-oversampled receiver and matching transmitter sharing one baud tick.
// Define UART8_TX_EN to build the transmitter; otherwise tx idles high and tx inputs are ignored.
module uart8_rx_tx #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState;

    logic [DW-1:0] divCnt;
    logic          tick;

    assign tick = (divCnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) divCnt <= '0;
        else             divCnt <= divCnt + 1'b1;
    end

    logic [1:0] rxSync;
    logic       rxS;

    assign rxS = rxSync[1];

    always_ff @(posedge clk) begin
        if (rst) rxSync <= 2'b11;
        else     rxSync <= {rxSync[0], rx};
    end

    uartState   rxState;
    logic [3:0] rxTicks;
    logic [2:0] rxBit;
    logic [7:0] rxShift;

    // Start is confirmed mid-bit (8 ticks); every later sample lands 16 ticks on.
    always_ff @(posedge clk) begin
        rxDone <= 1'b0;
        rxErr  <= 1'b0;
        if (rst) begin
            rxState <= IDLE;
            rxBusy  <= 1'b0;
            out     <= 8'h00;
            rxTicks <= 4'd0;
            rxBit   <= 3'd0;
            rxShift <= 8'h00;
        end else if (!rxEn) begin
            rxState <= IDLE;
            rxBusy  <= 1'b0;
        end else begin
            case (rxState)
                IDLE: if (!rxS) begin
                    rxState <= START;
                    rxTicks <= 4'd0;
                    rxBusy  <= 1'b1;
                end
                START: if (tick) begin
                    if (rxTicks == 4'd7) begin
                        rxTicks <= 4'd0;
                        rxBit   <= 3'd0;
                        if (!rxS) begin
                            rxState <= DATA;
                        end else begin
                            rxState <= IDLE;
                            rxBusy  <= 1'b0;
                        end
                    end else begin
                        rxTicks <= rxTicks + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    rxTicks <= rxTicks + 1'b1;
                    if (rxTicks == 4'd15) begin
                        rxShift <= {rxS, rxShift[7:1]};
                        rxBit   <= rxBit + 1'b1;
                        if (rxBit == 3'd7) rxState <= STOP;
                    end
                end
                STOP: if (tick) begin
                    rxTicks <= rxTicks + 1'b1;
                    // Leave at the stop sample so a start edge half a bit later is caught.
                    if (rxTicks == 4'd15) begin
                        if (rxS) begin
                            out    <= rxShift;
                            rxDone <= 1'b1;
                        end else begin
                            rxErr  <= 1'b1;
                        end
                        rxState <= IDLE;
                        rxBusy  <= 1'b0;
                    end
                end
                default: rxState <= IDLE;
            endcase
        end
    end

`ifdef UART8_TX_EN
    uartState   txState;
    logic [3:0] txTicks;
    logic [2:0] txBit;
    logic [7:0] txShift;
    logic       txLead;

    // txLead waits for the next tick so every bit, including start, is exactly 16 ticks.
    always_ff @(posedge clk) begin
        txDone <= 1'b0;
        if (rst) begin
            txState <= IDLE;
            tx      <= 1'b1;
            txBusy  <= 1'b0;
            txTicks <= 4'd0;
            txBit   <= 3'd0;
            txShift <= 8'h00;
            txLead  <= 1'b0;
        end else begin
            case (txState)
                IDLE: if (txEn && txStart) begin
                    txShift <= in;
                    txBusy  <= 1'b1;
                    txLead  <= 1'b1;
                    txTicks <= 4'd0;
                    txBit   <= 3'd0;
                    txState <= START;
                end
                START: if (tick) begin
                    if (txLead) begin
                        tx     <= 1'b0;
                        txLead <= 1'b0;
                    end else begin
                        txTicks <= txTicks + 1'b1;
                        if (txTicks == 4'd15) begin
                            tx      <= txShift[0];
                            txShift <= {1'b1, txShift[7:1]};
                            txState <= DATA;
                        end
                    end
                end
                DATA: if (tick) begin
                    txTicks <= txTicks + 1'b1;
                    if (txTicks == 4'd15) begin
                        txBit <= txBit + 1'b1;
                        if (txBit == 3'd7) begin
                            tx      <= 1'b1;
                            txState <= STOP;
                        end else begin
                            tx      <= txShift[0];
                            txShift <= {1'b1, txShift[7:1]};
                        end
                    end
                end
                STOP: if (tick) begin
                    txTicks <= txTicks + 1'b1;
                    if (txTicks == 4'd15) begin
                        txDone  <= 1'b1;
                        txBusy  <= 1'b0;
                        txState <= IDLE;
                    end
                end
                default: txState <= IDLE;
            endcase
        end
    end
`else
    logic unusedTx;
    assign unusedTx = txEn ^ txStart ^ (^in);
    assign tx       = 1'b1;
    assign txBusy   = 1'b0;
    assign txDone   = 1'b0;
`endif

endmodule

// File: tb/tb_uart8_rx_tx.sv
// Bench for uart8_rx_tx: a table of rx frames scored against a frame-level model,
// plus glitch, back-to-back, abort and (with UART8_TX_EN) loopback sequences.
`timescale 1ns/1ps
module tb_uart8_rx_tx;
    localparam int CLOCK_RATE = 1000000;
    localparam int BAUD_RATE  = 6000;
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int BIT = 16 * DIV;

    typedef struct {
        logic [7:0] data;
        int         bitLen;
        logic       stopHigh;
        int         stopLen;
        logic       expDone;
        logic       expErr;
    } rxVec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxEn = 1'b0;
    logic       rxLine = 1'b1;
    logic       loopBack = 1'b0;
    logic       rx;
    logic       rxBusy, rxDone, rxErr;
    logic [7:0] out;
    logic       txEn = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] in = 8'h00;
    logic       txBusy, txDone, tx;

    assign rx = loopBack ? tx : rxLine;

    uart8_rx_tx #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst(rst), .rxEn(rxEn), .rx(rx), .rxBusy(rxBusy), .rxDone(rxDone),
        .rxErr(rxErr), .out(out), .txEn(txEn), .txStart(txStart), .in(in),
        .txBusy(txBusy), .txDone(txDone), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int         doneCnt = 0, errCnt = 0, txDoneCnt = 0, widthViol = 0;
    logic       prevDone = 1'b0, prevErr = 1'b0, prevTxDone = 1'b0;
    logic [7:0] gotQ[$];

    always @(negedge clk) begin
        if (rxDone) begin
            doneCnt++;
            gotQ.push_back(out);
        end
        if (rxErr)  errCnt++;
        if (txDone) txDoneCnt++;
        if ((rxDone && prevDone) || (rxErr && prevErr) || (txDone && prevTxDone)) widthViol++;
        prevDone   = rxDone;
        prevErr    = rxErr;
        prevTxDone = txDone;
    end

    task automatic waitN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input int bl, input logic stopV, input int stopLen);
        rxLine = 1'b0;
        waitN(bl);
        for (int i = 0; i < 8; i++) begin
            rxLine = d[i];
            waitN(bl);
        end
        rxLine = stopV;
        waitN(stopLen);
        rxLine = 1'b1;
    endtask

`ifdef UART8_TX_EN
    // Expected waveform is the run-length encoding of {stop, data, start}.
    task automatic loopFrame(input logic [7:0] d, input logic poke);
        logic bits[10];
        int   lat, i, j, n, t0, d0;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        bits[9] = 1'b1;
        t0 = txDoneCnt;
        d0 = doneCnt;
        in = d;
        txEn = 1'b1;
        txStart = 1'b1;
        waitN(1);
        txStart = 1'b0;
        txEn = poke;
        check("txBusy after start", 32'(txBusy), 32'd1);
        lat = 0;
        while (tx !== 1'b0 && lat < 4 * DIV) begin
            waitN(1);
            lat++;
        end
        check("tx start latency", 32'(lat <= DIV), 32'd1);
        if (poke) begin
            in = 8'hFF;
            txStart = 1'b1;
        end
        i = 0;
        while (i < 10) begin
            j = i;
            while (j < 10 && bits[j] == bits[i]) j++;
            n = 0;
            if (j == 10) begin
                while (txDone !== 1'b1 && n < 12 * BIT) begin waitN(1); n++; end
            end else begin
                while (tx === bits[i] && n < 12 * BIT) begin waitN(1); n++; end
            end
            check($sformatf("tx run at bit %0d of 0x%0h", i, d), 32'(n), 32'((j - i) * BIT));
            txStart = 1'b0;
            i = j;
        end
        waitN(2);
        check("txBusy after frame", 32'(txBusy), 32'd0);
        waitN(BIT);
        check("txDone count", 32'(txDoneCnt - t0), 32'd1);
        check("loopback rxDone", 32'(doneCnt - d0), 32'd1);
        check("loopback out", 32'(out), 32'(d));
        txEn = 1'b0;
    endtask
`endif

    rxVec       vecs[10];
    logic [7:0] expOut;
    int         d0, e0, n;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h56, 165, 1'b1, 165, 1'b1, 1'b0};
        vecs[1] = '{8'h56, 155, 1'b1, 155, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, BIT, 1'b0, 3 * BIT / 4, 1'b0, 1'b1};
        vecs[3] = '{8'h00, BIT, 1'b1, BIT, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, BIT, 1'b1, BIT, 1'b1, 1'b0};
        for (int i = 5; i < 10; i++) begin
            vecs[i].data     = 8'($urandom_range(0, 255));
            vecs[i].stopHigh = ($urandom_range(0, 3) != 0);
            vecs[i].bitLen   = vecs[i].stopHigh ? int'($urandom_range(156, 164)) : BIT;
            vecs[i].stopLen  = vecs[i].stopHigh ? vecs[i].bitLen : 3 * BIT / 4;
            vecs[i].expDone  = vecs[i].stopHigh;
            vecs[i].expErr   = !vecs[i].stopHigh;
        end

        waitN(5);
        check("reset rxBusy", 32'(rxBusy), 32'd0);
        check("reset rxDone", 32'(rxDone), 32'd0);
        check("reset rxErr",  32'(rxErr),  32'd0);
        check("reset out",    32'(out),    32'd0);
        check("reset tx",     32'(tx),     32'd1);
        check("reset txBusy", 32'(txBusy), 32'd0);
        check("reset txDone", 32'(txDone), 32'd0);
        rst = 1'b0;
        rxEn = 1'b1;
        expOut = 8'h00;
        waitN(BIT);

        for (int i = 0; i < 10; i++) begin
            d0 = doneCnt;
            e0 = errCnt;
            sendFrame(vecs[i].data, vecs[i].bitLen, vecs[i].stopHigh, vecs[i].stopLen);
            waitN(2 * BIT);
            if (vecs[i].expDone) expOut = vecs[i].data;
            check($sformatf("vec%0d rxDone", i), 32'(doneCnt - d0), 32'(vecs[i].expDone));
            check($sformatf("vec%0d rxErr", i),  32'(errCnt - e0),  32'(vecs[i].expErr));
            check($sformatf("vec%0d out", i),    32'(out),          32'(expOut));
            check($sformatf("vec%0d rxBusy", i), 32'(rxBusy),       32'd0);
        end

        // Start glitch shorter than half a bit
        d0 = doneCnt;
        e0 = errCnt;
        rxLine = 1'b0;
        waitN(10);
        check("glitch rxBusy high", 32'(rxBusy), 32'd1);
        waitN(14);
        rxLine = 1'b1;
        waitN(BIT);
        check("glitch rxBusy low", 32'(rxBusy), 32'd0);
        check("glitch rxDone", 32'(doneCnt - d0), 32'd0);
        check("glitch rxErr", 32'(errCnt - e0), 32'd0);
        check("glitch out", 32'(out), 32'(expOut));

        // Back-to-back frames with a shortened stop bit
        d0 = doneCnt;
        sendFrame(8'h3A, BIT, 1'b1, 100);
        sendFrame(8'h56, BIT, 1'b1, BIT);
        waitN(2 * BIT);
        expOut = 8'h56;
        check("b2b rxDone count", 32'(doneCnt - d0), 32'd2);
        if (gotQ.size() >= 2) check("b2b first byte", 32'(gotQ[gotQ.size() - 2]), 32'h3A);
        check("b2b out", 32'(out), 32'(expOut));

        // rxEn drop mid-frame
        d0 = doneCnt;
        e0 = errCnt;
        fork
            sendFrame(8'h11, BIT, 1'b1, BIT);
            begin
                waitN(5 * BIT);
                check("rxEn abort busy before", 32'(rxBusy), 32'd1);
                rxEn = 1'b0;
                waitN(1);
                check("rxEn abort busy after", 32'(rxBusy), 32'd0);
            end
        join
        waitN(2 * BIT);
        check("rxEn abort rxDone", 32'(doneCnt - d0), 32'd0);
        check("rxEn abort rxErr", 32'(errCnt - e0), 32'd0);
        check("rxEn abort out", 32'(out), 32'(expOut));
        rxEn = 1'b1;
        sendFrame(8'h5A, BIT, 1'b1, BIT);
        waitN(2 * BIT);
        expOut = 8'h5A;
        check("after rxEn abort rxDone", 32'(doneCnt - d0), 32'd1);
        check("after rxEn abort out", 32'(out), 32'(expOut));

        // Reset mid-frame
        d0 = doneCnt;
        e0 = errCnt;
        fork
            sendFrame(8'hC3, BIT, 1'b1, BIT);
            begin
                waitN(4 * BIT);
                check("rst abort busy before", 32'(rxBusy), 32'd1);
                rst = 1'b1;
                waitN(1);
                check("rst abort busy after", 32'(rxBusy), 32'd0);
                check("rst abort out", 32'(out), 32'd0);
            end
        join
        rst = 1'b0;
        expOut = 8'h00;
        waitN(2 * BIT);
        check("rst abort rxDone", 32'(doneCnt - d0), 32'd0);
        check("rst abort rxErr", 32'(errCnt - e0), 32'd0);
        sendFrame(8'h96, BIT, 1'b1, BIT);
        waitN(2 * BIT);
        expOut = 8'h96;
        check("after rst rxDone", 32'(doneCnt - d0), 32'd1);
        check("after rst out", 32'(out), 32'(expOut));

`ifdef UART8_TX_EN
        loopBack = 1'b1;
        waitN(BIT);
        loopFrame(8'h3C, 1'b0);
        loopFrame(8'($urandom_range(0, 255)), 1'b1);
        in = 8'h00;
        txEn = 1'b1;
        txStart = 1'b1;
        waitN(1);
        txStart = 1'b0;
        waitN(3 * BIT);
        check("tx rst busy before", 32'(txBusy), 32'd1);
        rst = 1'b1;
        waitN(1);
        check("tx rst line", 32'(tx), 32'd1);
        check("tx rst busy after", 32'(txBusy), 32'd0);
        rst = 1'b0;
        txEn = 1'b0;
        waitN(2 * BIT);
        check("tx rst no txDone", 32'(txDone), 32'd0);
        loopBack = 1'b0;
`else
        n = 0;
        d0 = txDoneCnt;
        txEn = 1'b1;
        in = 8'hA5;
        txStart = 1'b1;
        for (int i = 0; i < 2 * BIT; i++) begin
            waitN(1);
            if (tx !== 1'b1 || txBusy !== 1'b0) n++;
        end
        txStart = 1'b0;
        txEn = 1'b0;
        check("tx tied idle", 32'(n), 32'd0);
        check("tx no txDone", 32'(txDoneCnt - d0), 32'd0);
`endif

        check("pulse widths", 32'(widthViol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
